// File: rtl/hpspbram_rd_arbiter_if.sv
// Requester-side bundle of the BRAM read arbiter: request handshake plus
// the tagged response. The arbiter takes the slave view; requesters (or a
// bench) drive the master view.
interface hpspbram_rd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 678
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/hpspbram_rd_arbiter.sv
// Round-robin sharing of the BRAM read port among NUM_REQ requesters.
// A grant drives the BRAM read combinationally in the same cycle; a tag
// pipeline as deep as the BRAM read latency steers the returned data back
// to the requester that issued the read.
module hpspbram_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 678,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clka,
  input  logic                 rstb,
  hpspbram_rd_arbiter_if.slave req_if,
  output logic [ADDR_W-1:0]    bram_addrb,
  output logic                 bram_enb,
  output logic                 bram_regceb,
  output logic                 bram_rstb,
  input  logic [DATA_W-1:0]    bram_doutb
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("hpspbram_rd_arbiter: RD_LATENCY must be 1 or 2, got %0d", RD_LATENCY);
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("hpspbram_rd_arbiter: NUM_REQ must be 2..8, got %0d", NUM_REQ);
    end
  endgenerate

  logic [IDX_W-1:0]      last_q, last_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  gnt_any;
  logic [IDX_W-1:0]      gnt_id;
  logic [IDX_W-1:0]      cand;
  logic [ADDR_W-1:0]     gnt_addr;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]      tag_id_q [RD_LATENCY];
  logic [IDX_W-1:0]      tag_id_d [RD_LATENCY];

  // Search from last+1 with wrap; first valid requester wins. Reset blocks all grants.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = last_q;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_any && !rstb && req_if.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Grant vector, BRAM read issue and next-state of pointer / address shadow.
  always_comb begin
    gnt_addr         = req_if.req_addr[gnt_id*ADDR_W +: ADDR_W];
    req_if.req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    bram_enb         = gnt_any;
    addr_d           = gnt_any ? gnt_addr : addr_q;
    last_d           = gnt_any ? gnt_id : last_q;
    bram_addrb       = rstb ? '0 : addr_d;
  end

  // Tag pipeline shift: stage 0 takes this cycle's grant.
  always_comb begin
    tag_vld_d[0] = gnt_any;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s < RD_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  // Control state: pointer, address shadow, tag valids (reset drops in-flight reads).
  always_ff @(posedge clka) begin
    if (rstb) begin
      last_q    <= IDX_W'(NUM_REQ - 1);
      addr_q    <= '0;
      tag_vld_q <= '0;
    end else begin
      last_q    <= last_d;
      addr_q    <= addr_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // Tag ids only matter alongside their valid bit, so they need no reset.
  always_ff @(posedge clka) begin
    tag_id_q <= tag_id_d;
  end

  // Response steering and BRAM output-register controls.
  always_comb begin
    req_if.rsp_valid = '0;
    if (!rstb && tag_vld_q[RD_LATENCY-1]) begin
      req_if.rsp_valid = NUM_REQ'(1) << tag_id_q[RD_LATENCY-1];
    end
    bram_regceb = (RD_LATENCY == 2) ? (tag_vld_q[0] && !rstb) : 1'b0;
  end

  assign req_if.rsp_data = bram_doutb;
  assign bram_rstb       = rstb;

endmodule

// File: tb/tb_hpspbram_rd_arbiter.sv
// Two arbiter instances: A (2 requesters, latency 1) and B (3 requesters,
// latency 2), each in front of a behavioural BRAM sharing one write port.
module tb_hpspbram_rd_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } ent_t;

  logic clka = 1'b0;
  logic rstb;
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int last_a, last_b;
  ent_t qa[$];
  ent_t qb[$];

  hpspbram_rd_arbiter_if #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  hpspbram_rd_arbiter_if #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  logic [AW-1:0] addrb_a, addrb_b;
  logic          enb_a, enb_b, regce_a, regce_b, brst_a, brst_b;
  logic [DW-1:0] dout_a, dout_b, lat_b;

  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  hpspbram_rd_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_a (
    .clka(clka), .rstb(rstb), .req_if(ifa),
    .bram_addrb(addrb_a), .bram_enb(enb_a), .bram_regceb(regce_a),
    .bram_rstb(brst_a), .bram_doutb(dout_a)
  );

  hpspbram_rd_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) u_b (
    .clka(clka), .rstb(rstb), .req_if(ifb),
    .bram_addrb(addrb_b), .bram_enb(enb_b), .bram_regceb(regce_b),
    .bram_rstb(brst_b), .bram_doutb(dout_b)
  );

  // BRAM A: no output register (read-first)
  always @(posedge clka) begin
    if (we) mem_a[wa] <= wd;
    if (enb_a) dout_a <= mem_a[addrb_a];
  end

  // BRAM B: with output register
  always @(posedge clka) begin
    if (we) mem_b[wa] <= wd;
    if (enb_b) lat_b <= mem_b[addrb_b];
    if (brst_b) dout_b <= '0;
    else if (regce_b) dout_b <= lat_b;
  end

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 3) return 16'h00A5;
    if (i == 7) return 16'h0011;
    return DW'(16'h1100 + i * 16'h0101);
  endfunction

  function automatic int rr_pick(input logic [7:0] v, input int last, input int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic issue_a(input logic [1:0] v, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, output int g);
    @(posedge clka); #1;
    ifa.req_valid = v;
    ifa.req_addr  = {a1, a0};
    @(negedge clka);
    g = rr_pick(8'(v), last_a, 2);
    if (g >= 0) begin
      qa.push_back('{g, mem_a[(g == 0) ? a0 : a1], cyc + 1});
      last_a = g;
    end
  endtask

  task automatic issue_b(input logic [2:0] v, input logic [3*AW-1:0] addrs, output int g);
    @(posedge clka); #1;
    ifb.req_valid = v;
    ifb.req_addr  = addrs;
    @(negedge clka);
    g = rr_pick(8'(v), last_b, 3);
    if (g >= 0) begin
      qb.push_back('{g, mem_b[addrs[g*AW +: AW]], cyc + 2});
      last_b = g;
    end
  endtask

  // Scoreboard: pop responses when due, otherwise require silence
  initial begin : mon
    ent_t e;
    logic [1:0]    ev_a;
    logic [2:0]    ev_b;
    logic [DW-1:0] ed_a, ed_b;
    forever begin
      @(negedge clka);
      ev_a = '0; ed_a = '0; ev_b = '0; ed_b = '0;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front(); ev_a = 2'(1) << e.id; ed_a = e.data;
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        e = qb.pop_front(); ev_b = 3'(1) << e.id; ed_b = e.data;
      end
      n_tests++;
      if (ifa.rsp_valid !== ev_a || (ev_a != 0 && ifa.rsp_data !== ed_a)) begin
        n_fail++;
        $display("FAIL rsp_a cyc=%0d: valid=%b data=%h, required valid=%b data=%h",
                 cyc, ifa.rsp_valid, ifa.rsp_data, ev_a, ed_a);
      end
      n_tests++;
      if (ifb.rsp_valid !== ev_b || (ev_b != 0 && ifb.rsp_data !== ed_b)) begin
        n_fail++;
        $display("FAIL rsp_b cyc=%0d: valid=%b data=%h, required valid=%b data=%h",
                 cyc, ifb.rsp_valid, ifb.rsp_data, ev_b, ed_b);
      end
    end
  end

  task automatic test_reset();
    rstb = 1'b1;
    ifa.req_valid = '1; ifa.req_addr = '1;
    ifb.req_valid = '1; ifb.req_addr = '1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clka); #1;
      we = 1'b1; wa = AW'(i); wd = init_val(i);
    end
    @(posedge clka); #1;
    we = 1'b0;
    @(negedge clka);
    n_tests++;
    if (ifa.req_ready !== 2'b00 || ifb.req_ready !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: a=%b b=%b, required 0", ifa.req_ready, ifb.req_ready);
    end
    n_tests++;
    if ({enb_a, enb_b, regce_a, regce_b} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_en: enb/regce=%b, required 0000", {enb_a, enb_b, regce_a, regce_b});
    end
    n_tests++;
    if (addrb_a !== 4'd0 || addrb_b !== 4'd0) begin
      n_fail++; $display("FAIL reset_addr: a=%h b=%h, required 0", addrb_a, addrb_b);
    end
    n_tests++;
    if (brst_a !== 1'b1 || brst_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_bram_rstb: a=%b b=%b, required 1", brst_a, brst_b);
    end
    @(posedge clka); #1;
    rstb = 1'b0;
    ifa.req_valid = '0; ifb.req_valid = '0;
    last_a = 1; last_b = 2;
    @(negedge clka);
    n_tests++;
    if ({ifa.req_ready, ifb.req_ready, enb_a, enb_b, regce_b, brst_a, brst_b} !== 10'b0) begin
      n_fail++; $display("FAIL post_reset_ctrl: ready/en/rst=%b, required 0",
                         {ifa.req_ready, ifb.req_ready, enb_a, enb_b, regce_b, brst_a, brst_b});
    end
    n_tests++;
    if (addrb_a !== 4'd0 || addrb_b !== 4'd0) begin
      n_fail++; $display("FAIL post_reset_addr: a=%h b=%h, required 0", addrb_a, addrb_b);
    end
  endtask

  task automatic test_lone_requester();
    int g;
    issue_a(2'b01, 4'd3, 4'd0, g);
    n_tests++;
    if (ifa.req_ready !== 2'b01 || enb_a !== 1'b1 || addrb_a !== 4'd3) begin
      n_fail++; $display("FAIL lone_issue: ready=%b enb=%b addr=%h, required 01 1 3", ifa.req_ready, enb_a, addrb_a);
    end
    issue_a(2'b00, 4'd0, 4'd0, g);
    n_tests++;
    if (ifa.rsp_valid !== 2'b01 || ifa.rsp_data !== 16'h00A5) begin
      n_fail++; $display("FAIL lone_rsp: valid=%b data=%h, required 01 00a5", ifa.rsp_valid, ifa.rsp_data);
    end
    for (int k = 0; k < 3; k++) begin
      issue_a(2'b10, 4'd0, 4'd9, g);
      n_tests++;
      if (ifa.req_ready !== 2'b10 || addrb_a !== 4'd9) begin
        n_fail++; $display("FAIL lone_req1[%0d]: ready=%b addr=%h, required 10 9", k, ifa.req_ready, addrb_a);
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    for (int k = 0; k < 6; k++) begin
      issue_a(2'b11, 4'd1, 4'd2, g);
      n_tests++;
      if (ifa.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || enb_a !== 1'b1 ||
          addrb_a !== ((k % 2 == 0) ? 4'd1 : 4'd2)) begin
        n_fail++; $display("FAIL fair_a[%0d]: ready=%b enb=%b addr=%h", k, ifa.req_ready, enb_a, addrb_a);
      end
    end
    issue_a(2'b00, 4'd0, 4'd0, g);
  endtask

  task automatic test_read_during_write();
    @(posedge clka); #1;
    we = 1'b1; wa = 4'd7; wd = 16'h0055;
    ifa.req_valid = 2'b01; ifa.req_addr = {4'd0, 4'd7};
    @(negedge clka);
    n_tests++;
    if (ifa.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rdw_grant: ready=%b, required 01", ifa.req_ready);
    end
    qa.push_back('{0, 16'h0011, cyc + 1});
    last_a = 0;
    @(posedge clka); #1;
    we = 1'b0;
    @(negedge clka);
    n_tests++;
    if (ifa.rsp_data !== 16'h0011 || ifa.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rdw_old: data=%h ready=%b, required 0011 01", ifa.rsp_data, ifa.req_ready);
    end
    qa.push_back('{0, 16'h0055, cyc + 1});
    @(posedge clka); #1;
    ifa.req_valid = 2'b00;
    @(negedge clka);
    n_tests++;
    if (ifa.rsp_data !== 16'h0055) begin
      n_fail++; $display("FAIL rdw_new: data=%h, required 0055", ifa.rsp_data);
    end
  endtask

  task automatic test_idle();
    logic [AW-1:0] ha, hb;
    @(posedge clka); #1;
    ifa.req_valid = '0; ifb.req_valid = '0;
    @(negedge clka);
    ha = addrb_a; hb = addrb_b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clka);
      n_tests++;
      if (enb_a !== 1'b0 || enb_b !== 1'b0 || addrb_a !== ha || addrb_b !== hb) begin
        n_fail++; $display("FAIL idle[%0d]: enb=%b%b addr=%h/%h, required 00 %h/%h",
                           k, enb_a, enb_b, addrb_a, addrb_b, ha, hb);
      end
    end
  endtask

  task automatic test_two_cycle_latency();
    int g;
    issue_b(3'b001, {4'd0, 4'd0, 4'd5}, g);
    n_tests++;
    if (ifb.req_ready !== 3'b001 || enb_b !== 1'b1 || addrb_b !== 4'd5) begin
      n_fail++; $display("FAIL lat2_issue: ready=%b enb=%b addr=%h, required 001 1 5", ifb.req_ready, enb_b, addrb_b);
    end
    issue_b(3'b000, '0, g);
    n_tests++;
    if (regce_b !== 1'b1 || ifb.rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL lat2_regce: regce=%b rsp=%b, required 1 000", regce_b, ifb.rsp_valid);
    end
    issue_b(3'b000, '0, g);
    n_tests++;
    if (ifb.rsp_valid !== 3'b001 || ifb.rsp_data !== init_val(5) || regce_b !== 1'b0) begin
      n_fail++; $display("FAIL lat2_rsp: valid=%b data=%h regce=%b, required 001 %h 0",
                         ifb.rsp_valid, ifb.rsp_data, regce_b, init_val(5));
    end
  endtask

  task automatic test_back_to_back();
    int g;
    for (int k = 0; k < 6; k++) begin
      issue_b(3'b111, {4'd3, 4'd2, 4'd1}, g);
      n_tests++;
      if (ifb.req_ready !== (3'b001 << ((k + 1) % 3)) || enb_b !== 1'b1 || regce_b !== (k > 0)) begin
        n_fail++; $display("FAIL b2b_b[%0d]: ready=%b enb=%b regce=%b", k, ifb.req_ready, enb_b, regce_b);
      end
    end
    issue_b(3'b000, '0, g);
    issue_b(3'b000, '0, g);
  endtask

  task automatic test_drop_and_wrap();
    int g;
    logic [2:0] dv [4] = '{3'b110, 3'b001, 3'b100, 3'b111};
    logic [2:0] de [4] = '{3'b010, 3'b001, 3'b100, 3'b001};
    for (int k = 0; k < 4; k++) begin
      issue_b(dv[k], {4'd12, 4'd11, 4'd10}, g);
      n_tests++;
      if (ifb.req_ready !== de[k]) begin
        n_fail++; $display("FAIL drop_wrap[%0d]: ready=%b, required %b", k, ifb.req_ready, de[k]);
      end
    end
    issue_b(3'b000, '0, g);
    issue_b(3'b000, '0, g);
  endtask

  task automatic test_reset_midflight();
    int g;
    issue_b(3'b010, {4'd0, 4'd6, 4'd0}, g);
    n_tests++;
    if (ifb.req_ready !== 3'b010) begin
      n_fail++; $display("FAIL mid_grant: ready=%b, required 010", ifb.req_ready);
    end
    @(posedge clka); #1;
    rstb = 1'b1;
    ifb.req_valid = '0;
    qa.delete(); qb.delete();
    @(negedge clka);
    n_tests++;
    if (ifb.rsp_valid !== 3'b000 || regce_b !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_cycle: rsp=%b regce=%b, required 000 0", ifb.rsp_valid, regce_b);
    end
    @(posedge clka); #1;
    rstb = 1'b0;
    last_a = 1; last_b = 2;
    @(negedge clka);
    n_tests++;
    if (ifb.rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL mid_after1: rsp=%b, required 000", ifb.rsp_valid);
    end
    issue_b(3'b111, {4'd9, 4'd8, 4'd2}, g);
    n_tests++;
    if (ifb.req_ready !== 3'b001 || addrb_b !== 4'd2 || ifb.rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL mid_first_grant: ready=%b addr=%h rsp=%b, required 001 2 000",
                         ifb.req_ready, addrb_b, ifb.rsp_valid);
    end
    for (int k = 0; k < 3; k++) issue_b(3'b000, '0, g);
  endtask

  initial begin
    rstb = 1'b1;
    we = 1'b0; wa = '0; wd = '0;
    ifa.req_valid = '0; ifa.req_addr = '0;
    ifb.req_valid = '0; ifb.req_addr = '0;
    last_a = 1; last_b = 2;
    test_reset();
    test_lone_requester();
    test_fairness();
    test_read_during_write();
    test_idle();
    test_two_cycle_latency();
    test_back_to_back();
    test_drop_and_wrap();
    test_reset_midflight();
    repeat (3) @(negedge clka);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++; $display("FAIL outstanding: a=%0d b=%0d responses never seen, required 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
